// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: store kinds, buffered entry layout and misalignment helper.
package store_buffer_pkg;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_SB   = 2'b01,
        ST_SH   = 2'b10,
        ST_SW   = 2'b11
    } st_type_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  web;
    } entry_t;

    localparam logic [3:0] WEB_NONE = 4'b1111;

    function automatic logic is_misaligned(input st_type_e kind, input logic [1:0] lane);
        return ((kind == ST_SH) && lane[0]) || ((kind == ST_SW) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/store_fmt.sv
// Combinational lane formatter: replicates store data across byte lanes and builds the
// active-low byte write enable from the store kind and low address bits.
module store_fmt
    import store_buffer_pkg::*;
(
    input  st_type_e    st_type,
    input  logic [1:0]  lane,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  web
);

    always_comb begin
        wdata = '0;
        web   = WEB_NONE;
        case (st_type)
            ST_SB: begin
                wdata = {4{data[7:0]}};
                web   = ~(4'b0001 << lane);
            end
            ST_SH: begin
                // Halfword lane is picked by bit 1 only; bit 0 is either ignored or trapped upstream.
                wdata = {2{data[15:0]}};
                web   = lane[1] ? 4'b0011 : 4'b1100;
            end
            ST_SW: begin
                wdata = data;
                web   = 4'b0000;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// DEPTH-entry FIFO of pre-formatted stores draining to data memory; full buffer or a load
// behind pending stores stalls the pipe. Optional macro STORE_MISALIGN_EN traps misaligned SH/SW.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        ld_req,
    output logic        stall,
    output logic        dm_req,
    input  logic        dm_ready,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_web,
    output logic        empty,
    output logic        misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            full;
    logic            has_store;
    logic            mis;
    logic            push;
    logic            pop;
    logic [31:0]     fmt_wdata;
    logic [3:0]      fmt_web;
    entry_t          head;

    store_fmt u_fmt (
        .st_type (st_type_e'(st_type)),
        .lane    (st_addr[1:0]),
        .data    (st_data),
        .wdata   (fmt_wdata),
        .web     (fmt_web)
    );

`ifdef STORE_MISALIGN_EN
    assign mis = st_valid && is_misaligned(st_type_e'(st_type), st_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign has_store = st_valid && (st_type != ST_NONE);
    // Acceptance depends only on registered fullness, never on this cycle's dequeue.
    assign push      = has_store && !full && !mis;
    assign pop       = !empty && dm_ready;
    assign stall     = (has_store && full && !mis) || (ld_req && !empty);

    assign head     = mem[rd_ptr];
    assign dm_req   = !empty;
    assign dm_addr  = empty ? 32'h0 : head.addr;
    assign dm_wdata = empty ? 32'h0 : head.wdata;
    assign dm_web   = empty ? WEB_NONE : head.web;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{addr: 32'h0, wdata: 32'h0, web: WEB_NONE};
            end
        end else begin
            misalign <= mis;
            if (push) begin
                mem[wr_ptr] <= '{addr: {st_addr[31:2], 2'b00}, wdata: fmt_wdata, web: fmt_web};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
